// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder:
// store-size codes, FSM states, byte-enable and alignment rules.
package dmem_pkg;

   typedef enum logic [1:0] {
      MW_LOAD = 2'b00,
      MW_BYTE,
      MW_HALF,
      MW_WORD
   } mw_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dstate_e;

   function automatic logic [3:0] byte_en(mw_e mw, logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (mw)
         MW_BYTE: be = 4'b0001 << off;
         MW_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         MW_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Loads of any width are legal at any offset.
   function automatic logic misaligned(mw_e mw, logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (mw)
         MW_HALF: bad = off[0];
         MW_WORD: bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: replicates store data across lanes with enables,
// and right-justifies the read word for the load path.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  mw_e         mw_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [31:0] wlane_o,
   output logic [3:0]  be_o,
   output logic [31:0] rdata_o
);

   always_comb begin
      wlane_o = wdata_i;
      case (mw_i)
         MW_BYTE: wlane_o = {4{wdata_i[7:0]}};
         MW_HALF: wlane_o = {2{wdata_i[15:0]}};
         default: wlane_o = wdata_i;
      endcase
   end

   assign be_o    = byte_en(mw_i, off_i);
   assign rdata_o = rword_i >> {off_i, 3'b000};

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data memory for the MEM stage: stalls LATENCY cycles,
// commits byte-lane stores at the end of RESP, returns aligned loads.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic [1:0]  memwrite,
   input  logic [31:0] wdata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        done,
   output logic        err_align
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY) + 1;

   dstate_e          state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW+1:0]    addr_q;
   mw_e              mw_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rd_q;

   logic [31:0]      mem [DEPTH_WORDS];

   mw_e              mw_in;
   logic             bad;
   logic             accept;
   logic [IW+1:0]    op_addr;
   mw_e              op_mw;
   logic [31:0]      op_wdata;
   logic [IW-1:0]    op_idx;
   logic [31:0]      wlane;
   logic [3:0]       be;
   logic [31:0]      rshift;
   logic             unused_addr;

   assign unused_addr = ^addr[31:IW+2];

   assign mw_in  = mw_e'(memwrite);
   assign bad    = misaligned(mw_in, addr[1:0]);
   assign accept = (state_q == IDLE) && req && !bad;

   // Live inputs steer the op in IDLE; the latched copy afterwards.
   assign op_addr  = (state_q == IDLE) ? addr[IW+1:0] : addr_q;
   assign op_mw    = (state_q == IDLE) ? mw_in : mw_q;
   assign op_wdata = (state_q == IDLE) ? wdata : wdata_q;
   assign op_idx   = op_addr[IW+1:2];

   dmem_lane_align u_align (
      .mw_i    (op_mw),
      .off_i   (op_addr[1:0]),
      .wdata_i (op_wdata),
      .rword_i (mem[op_idx]),
      .wlane_o (wlane),
      .be_o    (be),
      .rdata_o (rshift)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY > 1) begin
                  state_d = WAIT;
                  cnt_d   = CW'(LATENCY - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall     = 1'b0;
      done      = 1'b0;
      err_align = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall     = req && !bad;
            err_align = req && bad;
         end
         WAIT:    stall = 1'b1;
         RESP:    done  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         mw_q    <= MW_LOAD;
         wdata_q <= '0;
         rd_q    <= '0;
      end else begin
         if (accept) begin
            addr_q  <= addr[IW+1:0];
            mw_q    <= mw_in;
            wdata_q <= wdata;
         end
         // Load data is captured on the edge entering RESP.
         if (state_d == RESP && op_mw == MW_LOAD) rd_q <= rshift;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == RESP) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[op_idx][8*k +: 8] <= wlane[8*k +: 8];
         end
      end
   end

   assign readdata = rd_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 1) against a
// byte-addressed reference memory, directed steps then random traffic.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req   [2];
   logic [31:0] addr  [2];
   logic [1:0]  mw    [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        stall [2];
   logic        done  [2];
   logic        err   [2];

   logic [31:0] mdl     [2][256];
   logic [31:0] last_rd [2];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
      .clk(clk), .reset(rst_n), .req(req[0]), .addr(addr[0]),
      .memwrite(mw[0]), .wdata(wdata[0]), .readdata(rdata[0]),
      .stall(stall[0]), .done(done[0]), .err_align(err[0])
   );

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(rst_n), .req(req[1]), .addr(addr[1]),
      .memwrite(mw[1]), .wdata(wdata[1]), .readdata(rdata[1]),
      .stall(stall[1]), .done(done[1]), .err_align(err[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [1:0] m);
      return (m == 2'd3) ? 4 : (m == 2'd2) ? 2 : 1;
   endfunction

   function automatic bit model_bad(input logic [1:0] m, input logic [31:0] a);
      return (m != 2'd0) && ((a % size_of(m)) != 0);
   endfunction

   task automatic model_store(input int d, input logic [31:0] a,
                              input logic [1:0] m, input logic [31:0] wd);
      int idx, off;
      idx = int'((a / 4) % 256);
      off = int'(a % 4);
      for (int i = 0; i < size_of(m); i++)
         mdl[d][idx][8*(off+i) +: 8] = wd[8*i +: 8];
   endtask

   function automatic logic [31:0] model_load(input int d, input logic [31:0] a);
      return mdl[d][(a / 4) % 256] >> (8 * (a % 4));
   endfunction

   function automatic logic [31:0] flags(input int d);
      return {29'b0, stall[d], done[d], err[d]};
   endfunction

   // Called at start of a cycle (just after a rising edge).
   task automatic acc(input int d, input logic [31:0] a, input logic [1:0] m,
                      input logic [31:0] wd, input string tag);
      int lat;
      lat = (d == 0) ? 2 : 1;
      req[d] = 1'b1; addr[d] = a; mw[d] = m; wdata[d] = wd;
      @(negedge clk);
      if (model_bad(m, a)) begin
         chk({tag, "_err"}, flags(d), 32'd1);
         @(posedge clk); #1;
         req[d] = 1'b0;
         return;
      end
      chk({tag, "_req"}, flags(d), 32'd4);
      @(posedge clk); #1;
      for (int c = 1; c < lat; c++) begin
         req[d] = 1'b1; addr[d] = $urandom; mw[d] = 2'($urandom);
         wdata[d] = $urandom;
         @(negedge clk);
         chk({tag, "_wait"}, flags(d), 32'd4);
         @(posedge clk); #1;
      end
      req[d] = 1'b0;
      @(negedge clk);
      chk({tag, "_resp"}, flags(d), 32'd2);
      if (m == 2'd0) last_rd[d] = model_load(d, a);
      else model_store(d, a, m, wd);
      chk({tag, "_rd"}, rdata[d], last_rd[d]);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  m;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; addr[d] = '0; mw[d] = '0; wdata[d] = '0;
         last_rd[d] = '0;
      end
      rst_n = 1'b0;
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_flags", flags(d), 32'd0);
         chk("rst_rd", rdata[d], 32'd0);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 64; w++)
            acc(d, 32'(w * 4), 2'd3, $urandom, "init");

      acc(0, 32'h10, 2'd3, 32'h11223344, "st_w10");
      acc(0, 32'h10, 2'd0, $urandom, "ld_w10");
      chk("ld_w10_val", rdata[0], 32'h11223344);
      acc(0, 32'h11, 2'd1, 32'h000000AB, "st_b11");
      acc(0, 32'h10, 2'd0, $urandom, "ld_b10");
      chk("ld_b10_val", rdata[0], 32'h1122AB44);
      acc(0, 32'h13, 2'd0, $urandom, "ld_b13");
      chk("ld_b13_val", rdata[0], 32'h00000011);
      acc(0, 32'h12, 2'd2, 32'h0000BEEF, "st_h12");
      chk("st_keeps_rd", rdata[0], 32'h00000011);
      acc(0, 32'h12, 2'd0, $urandom, "ld_h12");
      chk("ld_h12_val", rdata[0], 32'h0000BEEF);
      acc(0, 32'h10, 2'd0, $urandom, "ld_h10");
      chk("ld_h10_val", rdata[0], 32'hBEEFAB44);

      acc(0, 32'h21, 2'd2, 32'h5555AAAA, "mis_h21");
      acc(0, 32'h22, 2'd3, 32'h12345678, "mis_w22");
      acc(0, 32'h20, 2'd0, $urandom, "ld_w20");
      chk("mis_keep", rdata[0], mdl[0][8]);

      req[0] = 1'b1; addr[0] = 32'h40; mw[0] = 2'd3; wdata[0] = 32'hDEADBEEF;
      @(posedge clk); #1;
      req[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstw_flags", flags(0), 32'd0);
      chk("rstw_rd0", rdata[0], 32'd0);
      chk("rstw_rd1", rdata[1], 32'd0);
      last_rd[0] = '0; last_rd[1] = '0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      acc(0, 32'h40, 2'd0, $urandom, "ld_w40");
      chk("rstw_nowrite", rdata[0] === 32'hDEADBEEF ? 32'd1 : 32'd0,
          mdl[0][16] === 32'hDEADBEEF ? 32'd1 : 32'd0);

      acc(1, 32'h0, 2'd0, $urandom, "l1_ld0");
      acc(1, 32'h4, 2'd0, $urandom, "l1_ld4");
      acc(1, 32'h8, 2'd0, $urandom, "l1_ld8");
      acc(1, 32'h400, 2'd0, $urandom, "l1_wrap");
      chk("l1_wrap_val", rdata[1], mdl[1][0]);

      for (int n = 0; n < 600; n++) begin
         a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255));
         m = 2'($urandom);
         acc(n % 2, a, m, $urandom, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
